fnd_scan_controller: RTL and testbench



---
 rtl/fnd_pkg.sv | 46 ++++
 rtl/bin2bcd_seq.sv | 63 ++++++
 rtl/fnd_scan_controller.sv | 144 ++++++++++++++
 tb/tb_fnd_scan_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, FSM encoding and segment lookup for the 4-digit FND scan controller.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int MAX_VAL    = 9999;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] SEG_0     = 8'hc0;
  localparam logic [7:0] SEG_1     = 8'hf9;
  localparam logic [7:0] SEG_2     = 8'ha4;
  localparam logic [7:0] SEG_3     = 8'hb0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hf8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hff;
  localparam logic [7:0] SEG_DASH  = 8'hbf;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } fnd_state_e;

  // BCD nibble to segment pattern; a non-decimal nibble cannot occur, show dash if it does.
  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble binary-to-BCD converter: one iteration per clock, BIN_W iterations.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic             o_busy,
  output logic             o_last,
  output logic [15:0]      o_bcd
);

  localparam int SW = BIN_W + 16;
  localparam int CW = $clog2(BIN_W);

  logic [SW-1:0] r_sh;
  logic [SW-1:0] w_adj;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift.
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < 4; i++) begin
      if (r_sh[BIN_W+4*i +: 4] >= 4'd5) begin
        w_adj[BIN_W+4*i +: 4] = r_sh[BIN_W+4*i +: 4] + 4'd3;
      end else begin
        w_adj[BIN_W+4*i +: 4] = r_sh[BIN_W+4*i +: 4];
      end
    end
  end

  assign o_last = r_busy && (r_cnt == CW'(BIN_W - 1));
  assign o_busy = r_busy;
  assign o_bcd  = r_sh[SW-1:BIN_W];

  // Load on start, then shift once per cycle until the last iteration has been applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_sh   <= {16'h0000, i_bin};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_sh  <= w_adj << 1;
      r_cnt <= r_cnt + CW'(1);
      if (o_last) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= 1'b1;
      end
    end else begin
      r_sh   <= r_sh;
      r_cnt  <= r_cnt;
      r_busy <= r_busy;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND sequencer: load/convert/commit FSM plus time-multiplexed scan.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int BIN_W    = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  input  logic             blank_lead,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       fnd_com,
  output logic [7:0]       fnd_data
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  fnd_state_e    r_state;
  logic          r_done;
  logic          r_ovf;
  logic          r_ovf_pend;
  logic [15:0]   r_disp;
  logic [PW-1:0] r_presc;
  logic [IW-1:0] r_idx;
  logic          w_start;
  logic          w_last;
  logic [15:0]   w_bcd;
  logic [3:0]    w_nib;
  logic          w_hi_zero;

  assign w_start = (r_state == ST_IDLE) && load;
  assign done    = r_done;
  assign ovf     = r_ovf;

  bin2bcd_seq #(.BIN_W(BIN_W)) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_bin   (value),
    .o_busy  (busy),
    .o_last  (w_last),
    .o_bcd   (w_bcd)
  );

  // Conversion FSM: accept a load only in IDLE, commit result (or overflow) one cycle after the last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_disp     <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (load) begin
            r_ovf_pend <= (value > BIN_W'(MAX_VAL));
            r_state    <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (w_last) begin
            r_done  <= 1'b1;
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_done <= 1'b0;
          r_ovf  <= r_ovf_pend;
          if (!r_ovf_pend) begin
            r_disp <= w_bcd;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running prescaler and digit index; independent of the conversion FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(TICK_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= r_idx + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
      r_idx   <= r_idx;
    end
  end

  // Select the active digit, decide blanking/overflow, and encode segments and common enables.
  always_comb begin
    w_nib     = 4'd0;
    w_hi_zero = 1'b0;
    fnd_com   = 4'b1110;
    case (r_idx)
      2'd0: begin
        w_nib     = r_disp[3:0];
        w_hi_zero = 1'b0;
        fnd_com   = 4'b1110;
      end
      2'd1: begin
        w_nib     = r_disp[7:4];
        w_hi_zero = (r_disp[15:4] == 12'h000);
        fnd_com   = 4'b1101;
      end
      2'd2: begin
        w_nib     = r_disp[11:8];
        w_hi_zero = (r_disp[15:8] == 8'h00);
        fnd_com   = 4'b1011;
      end
      2'd3: begin
        w_nib     = r_disp[15:12];
        w_hi_zero = (r_disp[15:12] == 4'h0);
        fnd_com   = 4'b0111;
      end
      default: begin
        w_nib     = 4'd0;
        w_hi_zero = 1'b0;
        fnd_com   = 4'b1110;
      end
    endcase
    if (r_ovf) begin
      fnd_data = SEG_DASH;
    end else if (blank_lead && w_hi_zero) begin
      fnd_data = SEG_BLANK;
    end else begin
      fnd_data = seg_encode(w_nib);
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: stimulus queues expected commits, a monitor checks every cycle.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] value = 14'd0;
  logic        load = 1'b0;
  logic        blank_lead = 1'b0;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;

  fnd_scan_controller #(.TICK_DIV(4), .BIN_W(14)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lead (blank_lead),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .fnd_com    (fnd_com),
    .fnd_data   (fnd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int v;
    int due;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          m_k = 0;
  int          m_val = 0;
  bit          m_ovf = 1'b0;
  bit          pend = 1'b0;
  int          pend_v = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          last_acc = 0;
  bit          has_acc = 1'b0;
  logic [7:0]  segtab [10] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99,
                               8'h92, 8'h82, 8'hf8, 8'h80, 8'h90};

  // Free-running cycle count used to time stimulus and expected done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Clocks elapsed since reset release; digit slot is floor(m_k/4) mod 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_k <= 0;
    else        m_k <= m_k + 1;
  end

  function automatic logic [7:0] exp_data(int v, bit ov, bit bl, int k);
    int p;
    int hi;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    hi = v / p;
    if (ov) return 8'hbf;
    if (bl && k != 0 && hi == 0) return 8'hff;
    return segtab[hi % 10];
  endfunction

  function automatic logic [3:0] exp_com(int k);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << k);
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: applies committed values, then compares handshake, overflow and scan outputs.
  always @(negedge clk) begin
    bit exp_busy;
    bit exp_done;
    int idx;
    if (!rst_n) begin
      q.delete();
      m_val = 0;
      m_ovf = 1'b0;
      pend  = 1'b0;
    end
    if (pend) begin
      if (pend_v > 9999) begin
        m_ovf = 1'b1;
      end else begin
        m_ovf = 1'b0;
        m_val = pend_v;
      end
      pend = 1'b0;
    end
    while (q.size() > 0 && cyc > q[0].due) void'(q.pop_front());
    exp_busy = (q.size() > 0) && (cyc >= q[0].due - 14) && (cyc <= q[0].due - 1);
    exp_done = (q.size() > 0) && (cyc == q[0].due);
    check("busy", int'(busy), int'(exp_busy));
    check("done", int'(done), int'(exp_done));
    check("ovf", int'(ovf), int'(m_ovf));
    idx = (m_k / 4) % 4;
    check("fnd_com", int'(fnd_com), int'(exp_com(idx)));
    check("fnd_data", int'(fnd_data), int'(exp_data(m_val, m_ovf, blank_lead, idx)));
    if (exp_done) begin
      pend_v = q[0].v;
      pend   = 1'b1;
      void'(q.pop_front());
    end
  end

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(int v);
    exp_t e;
    value = 14'(v);
    load  = 1'b1;
    if (!has_acc || cyc >= last_acc + 16) begin
      e.v   = v;
      e.due = cyc + 15;
      q.push_back(e);
      last_acc = cyc;
      has_acc  = 1'b1;
    end
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    rst_n   = 1'b1;
    has_acc = 1'b0;
    // Idle scan with and without leading-zero blanking.
    idle(20);
    blank_lead = 1'b1;
    idle(20);
    blank_lead = 1'b0;
    // Plain conversion.
    do_load(1234);
    idle(24);
    // Blanking with a single digit, then unblanked.
    blank_lead = 1'b1;
    do_load(7);
    idle(24);
    blank_lead = 1'b0;
    idle(20);
    // Overflow and recovery.
    do_load(10000);
    idle(24);
    do_load(9999);
    idle(24);
    // Loads during conversion and in COMMIT are dropped; N+16 is accepted.
    do_load(1234);
    idle(4);
    do_load(5678);
    idle(9);
    do_load(5678);
    do_load(5678);
    idle(24);
    // Reset in the middle of a conversion.
    do_load(4321);
    idle(6);
    rst_n = 1'b0;
    idle(3);
    rst_n   = 1'b1;
    has_acc = 1'b0;
    idle(30);
    // Randomized loads, gaps and blanking.
    for (int i = 0; i < 40; i++) begin
      blank_lead = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 99));
      else                           do_load($urandom_range(0, 12000));
      idle($urandom_range(0, 22));
    end
    idle(40);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
